// File: rtl/cmp_pkg.sv
// Shared types for the serial word comparator.
// State encoding, result codes and digit width.
package cmp_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

endpackage

// File: rtl/serial_word_comparator.sv
// Resolves word magnitude from MSB-first 2-bit digit compare flags.
// First decisive digit wins; result held until the next start.
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_valid,
    input  logic i_GT,
    input  logic i_LT,
    input  logic i_EQ,
    output logic o_ready,
    output logic o_done,
    output logic o_GT,
    output logic o_LT,
    output logic o_EQ,
    output logic o_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       res;
    logic             one_hot;
    logic             last;
    logic [1:0]       nxt_res;

    // Classify the incoming digit and fold it into the running decision.
    always_comb begin
        one_hot = 1'b0;
        nxt_res = res;
        last    = (cnt == LAST);
        unique case ({i_GT, i_LT, i_EQ})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
        if (res == RES_EQ && one_hot) begin
            if (i_GT)
                nxt_res = RES_GT;
            else if (i_LT)
                nxt_res = RES_LT;
        end
    end

    // Control FSM with counter, decision register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            res     <= RES_EQ;
            o_ready <= 1'b0;
            o_done  <= 1'b0;
            o_GT    <= 1'b0;
            o_LT    <= 1'b0;
            o_EQ    <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state   <= SCAN;
                        cnt     <= '0;
                        res     <= RES_EQ;
                        o_ready <= 1'b1;
                        o_GT    <= 1'b0;
                        o_LT    <= 1'b0;
                        o_EQ    <= 1'b0;
                        o_err   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (i_valid) begin
                        res <= nxt_res;
                        if (!one_hot)
                            o_err <= 1'b1;
                        if (last) begin
                            state   <= DONE;
                            o_ready <= 1'b0;
                            o_done  <= 1'b1;
                            o_GT    <= (nxt_res == RES_GT);
                            o_LT    <= (nxt_res == RES_LT);
                            o_EQ    <= (nxt_res == RES_EQ);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
